// File: rtl/audio_rate_buffer.sv
// Elastic sample FIFO between the bursty upstream audio path and the DAC:
// samples are written on data_ready and replayed at a fixed local sample rate.
//
// state | meaning
// FILL  | collecting samples until the prefill threshold, no playback
// PLAY  | one FIFO read per rate tick; an empty FIFO at a tick drops back to FILL
module audio_rate_buffer #(
    parameter int clock_max   = 25_000_000,
    parameter int sample_rate = 48_000,
    parameter int depth       = 16,
    parameter int prefill     = 8
) (
    input  logic                     clk_25mhz,
    input  logic                     reset,
    input  logic                     data_ready,
    input  logic [15:0]              audio_in,
    output logic [15:0]              audio_out,
    output logic                     sample_valid,
    output logic [$clog2(depth):0]   fifo_level,
    output logic                     overflow,
    output logic                     underrun
);

    localparam int DIV = clock_max / sample_rate;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(depth);
    localparam int LW  = AW + 1;
    localparam logic [CW-1:0] TICK_LAST   = CW'(DIV - 1);
    localparam logic [LW-1:0] FULL_LVL    = LW'(depth);
    localparam logic [LW-1:0] PREFILL_LVL = LW'(prefill);

    typedef enum logic {FILL = 1'b0, PLAY = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [15:0]   mem [depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty;
    logic          rd_en, wr_en, starve, drop;

    assign tick  = (tick_cnt == TICK_LAST);
    assign full  = (fifo_level == FULL_LVL);
    assign empty = (fifo_level == '0);

    // Free-running rate counter, independent of the FSM state.
    always_ff @(posedge clk_25mhz) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (fifo_level >= PREFILL_LVL) state_nxt = PLAY;
            PLAY: if (tick && empty)             state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        rd_en  = 1'b0;
        starve = 1'b0;
        if (state == PLAY && tick) begin
            rd_en  = !empty;
            starve = empty;
        end
    end

    // A write at full is still accepted when a read frees a slot on the same edge.
    assign wr_en = data_ready && (!full || rd_en);
    assign drop  = data_ready && full && !rd_en;

    always_ff @(posedge clk_25mhz) begin
        if (wr_en)
            mem[wr_ptr] <= audio_in;
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            audio_out    <= '0;
            sample_valid <= 1'b0;
            overflow     <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr    <= rd_ptr + 1'b1;
                audio_out <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            // An empty tick still strobes sample_valid to keep the DAC cadence.
            sample_valid <= rd_en | starve;
            overflow     <= drop;
            underrun     <= starve;
        end
    end

endmodule

// File: tb/tb_audio_rate_buffer.sv
// Randomized scoreboard bench for audio_rate_buffer: a queue-based reference
// model predicts every output event, a negedge monitor pops and compares.
module tb_audio_rate_buffer;

    localparam int DEPTH   = 8;
    localparam int PREFILL = 4;
    localparam int DIV     = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_ready = 1'b0;
    logic [15:0] audio_in = '0;
    logic [15:0] audio_out;
    logic        sample_valid;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic        underrun;

    always #5 clk = ~clk;

    audio_rate_buffer #(
        .clock_max(1000), .sample_rate(100), .depth(DEPTH), .prefill(PREFILL)
    ) dut (
        .clk_25mhz(clk), .reset(reset), .data_ready(data_ready), .audio_in(audio_in),
        .audio_out(audio_out), .sample_valid(sample_valid), .fifo_level(fifo_level),
        .overflow(overflow), .underrun(underrun)
    );

    typedef struct {
        int cyc;
        int audio;
        bit und;
        int lvl;
    } exp_t;

    int   total = 0, passed = 0;
    int   cyc = 0, t = 0, last = 0;
    bit   playing = 0;
    int   fq[$];
    exp_t exp_q[$];
    int   ov_q[$];
    int   n_valid = 0, n_und = 0, n_ov = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, req, req, cyc);
    endtask

    // Reference model: a sample queue plus a playing flag, ticking every DIV cycles.
    task automatic model_step();
        exp_t e;
        bit   tk;
        int   lvl0;
        bit   popd;
        cyc++;
        if (reset) begin
            fq.delete();
            playing = 0;
            t = 0;
            last = 0;
            return;
        end
        tk = (t % DIV) == DIV - 1;
        t++;
        lvl0 = fq.size();
        popd = 0;
        e = '{cyc: cyc, audio: 0, und: 0, lvl: 0};
        if (playing && tk) begin
            e.und = (lvl0 == 0);
            if (lvl0 > 0) begin
                last = fq.pop_front();
                popd = 1;
            end
            e.audio = last;
        end
        if (data_ready) begin
            if (lvl0 < DEPTH || popd) fq.push_back(int'(audio_in));
            else ov_q.push_back(cyc);
        end
        if (playing && tk) begin
            e.lvl = fq.size();
            exp_q.push_back(e);
        end
        if (playing) playing = !(tk && lvl0 == 0);
        else         playing = (lvl0 >= PREFILL);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (sample_valid || underrun) begin
            n_valid += int'(sample_valid);
            n_und   += int'(underrun);
            if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("audio_out", int'(audio_out), e.audio);
                chk("underrun_flag", int'(underrun), int'(e.und));
                chk("valid_with_underrun", int'(sample_valid), 1);
                chk("level_at_output", int'(fifo_level), e.lvl);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            chk("missing_output", 0, 1);
            void'(exp_q.pop_front());
        end
        if (overflow) begin
            n_ov++;
            if (ov_q.size() == 0) chk("unexpected_overflow", 1, 0);
            else chk("overflow_cycle", cyc, ov_q.pop_front());
        end else if (ov_q.size() > 0 && ov_q[0] <= cyc) begin
            chk("missing_overflow", 0, 1);
            void'(ov_q.pop_front());
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        data_ready = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input int v);
        data_ready = 1'b1;
        audio_in = v[15:0];
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    // Park on a negedge inside a tick cycle.
    task automatic align();
        int k = 0;
        while ((t % DIV) != DIV - 1 && k < 2 * DIV) begin
            @(negedge clk);
            k++;
        end
        chk("align_timeout", int'((t % DIV) == DIV - 1), 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_audio_out"}, int'(audio_out), 0);
        chk({tag, "_sample_valid"}, int'(sample_valid), 0);
        chk({tag, "_fifo_level"}, int'(fifo_level), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
    endtask

    initial begin
        int v0, u0, o0, rate;

        do_reset(3);
        check_reset_values("rst");
        v0 = n_valid;
        cycles(50);
        chk("idle_no_valid", n_valid - v0, 0);

        v0 = n_valid; u0 = n_und;
        for (int i = 1; i <= 4; i++) send(i);
        chk("prefill_level", int'(fifo_level), 4);
        chk("prefill_no_output", n_valid - v0, 0);
        cycles(60);
        chk("play_valid_count", n_valid - v0, 5);
        chk("play_underrun_count", n_und - u0, 1);
        chk("audio_holds_last", int'(audio_out), 4);
        v0 = n_valid;
        cycles(30);
        chk("fill_after_underrun", n_valid - v0, 0);

        align();
        o0 = n_ov;
        for (int i = 0; i < 10; i++) send(16'h0100 + i);
        chk("overflow_level", int'(fifo_level), 8);
        cycles(1);
        chk("overflow_count", n_ov - o0, 2);
        cycles(100);

        align();
        o0 = n_ov;
        for (int i = 0; i < 8; i++) send(16'h0200 + i);
        cycles(2);
        chk("full_before_beef", int'(fifo_level), 8);
        send(16'hBEEF);
        chk("full_level_kept", int'(fifo_level), 8);
        cycles(1);
        chk("full_rw_no_overflow", n_ov - o0, 0);
        cycles(100);

        for (int i = 0; i < 6; i++) send(16'h0300 + i);
        cycles(25);
        align();
        cycles(3);
        do_reset(1);
        check_reset_values("midrst");
        for (int i = 0; i < 4; i++) send(16'h0400 + i);
        cycles(60);

        for (int seg = 0; seg < 15; seg++) begin
            rate = $urandom_range(5, 25);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 999) == 0) begin
                    do_reset(1);
                end else begin
                    data_ready = ($urandom_range(0, 99) < rate);
                    audio_in = 16'($urandom);
                    @(negedge clk);
                end
            end
        end
        data_ready = 1'b0;
        cycles(30);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("overflow_q_drained", ov_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/audio_rate_buffer.md
# audio_rate_buffer

Elastic sample buffer between the audio path (SPI receiver / effect stage) and the DAC output stage. It accepts 16-bit samples whenever the upstream strobes `data_ready` and replays them at a fixed, locally generated sample rate, so the DAC sees evenly spaced samples regardless of SPI burst timing. It also reports over- and underrun so firmware can trim the sender's pacing.

## Interface
Parameters:
- `clock_max`, 25_000_000: system clock frequency in Hz.
- `sample_rate`, 48_000: output sample rate in Hz. `DIV = clock_max / sample_rate` (integer division, must be ≥ 2).
- `depth`, 16: FIFO depth in samples; power of two, ≥ 4.
- `prefill`, 8: samples required before playback starts; range 1..depth.

Ports:
- `clk_25mhz`  in  1: system clock; single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `data_ready`  in  1: one-cycle strobe; `audio_in` is valid in that cycle.
- `audio_in`  in  16: signed sample from upstream.
- `audio_out`  out  16: current output sample, registered; reset 16'h0000.
- `sample_valid`  out  1: one-cycle pulse when `audio_out` takes a new value; reset 0.
- `fifo_level`  out  $clog2(depth)+1: current occupancy, registered; reset 0.
- `overflow`  out  1: one-cycle pulse when a write is dropped; reset 0.
- `underrun`  out  1: one-cycle pulse when a tick finds the FIFO empty in PLAY; reset 0.

## Operation
- **Rate counter**
  - `tick_cnt` counts 0..DIV-1 and wraps.
  - `tick` is asserted combinationally in the cycle where `tick_cnt == DIV-1`.
  - The counter runs in every state and is cleared only by reset.
- **FIFO**
  - Circular buffer of `depth` entries with write and read pointers of $clog2(depth) bits, wrapping naturally.
  - Occupancy is tracked in a separate counter.
- **Write**
  - On `data_ready`, if not full (or if a read is also occurring that cycle), `mem[wr_ptr] <= audio_in` and `wr_ptr++`.
  - If full and no simultaneous read, the sample is dropped, pointers are unchanged and `overflow` pulses the next cycle.
- **State machine**: states FILL (reset state) and PLAY.
  - FILL: no reads; `audio_out` holds its value; `sample_valid` stays 0. Transition to PLAY when `fifo_level >= prefill`, evaluated on the registered level.
  - PLAY, on `tick`:
    - If not empty: `audio_out <= mem[rd_ptr]`, `rd_ptr++`, `sample_valid` pulses.
    - If empty: `audio_out` holds the last sample, `sample_valid` is still pulsed so the DAC cadence is kept, `underrun` pulses, and the next state is FILL.
- **Simultaneous write and read in the same cycle**
  - Both occur; the level is unchanged.
  - At full, the write is accepted because a slot frees that same edge.
  - At empty, the read does not see the incoming sample; this is an underrun.
- **Reset mid-operation**: contents are discarded; pointers, level, counter and all outputs return to reset values; state returns to FILL. Memory contents need not be cleared.

## Timing
- All outputs are registered.
- `fifo_level` reflects a write or read one cycle after the edge that sampled it.
- `audio_out` and `sample_valid` update on the edge that ends the tick cycle; the pulse lasts exactly 1 cycle.
- In PLAY, `sample_valid` pulses are exactly DIV cycles apart.
- Write-to-play latency from FILL:
  - The prefill-th write is followed 1 cycle later by `fifo_level == prefill`.
  - PLAY is entered on the next edge.
  - The first output comes at the next `tick` after that, so worst case is DIV+2 cycles.
- `overflow` and `underrun` are asserted on the cycle after the causing edge, for 1 cycle each.
- `data_ready` may be asserted on consecutive cycles; one sample is accepted per cycle.

## Test plan
All scenarios use `clock_max=1000`, `sample_rate=100` (DIV=10), `depth=8`, `prefill=4`.
1. **Reset values**: hold reset 3 cycles, release → `audio_out=0`, `sample_valid=0`, `fifo_level=0`, no pulses, and no `sample_valid` for 50 cycles.
2. **Prefill and ordered playback**: write 1, 2, 3, 4 on consecutive cycles → no output before level reaches 4; then `sample_valid` pulses 10 cycles apart with `audio_out` = 1, 2, 3, 4 in order.
3. **Underrun**: after scenario 2, send no more data → the fifth tick gives `underrun` for 1 cycle, `audio_out` stays 4, `sample_valid` still pulses, and the block returns to FILL (no further pulses until 4 new writes).
4. **Overflow**: in FILL, write 10 samples 16'h0100..16'h0109 back to back → `fifo_level=8` and `overflow` pulses twice; playback then outputs 16'h0100..16'h0107 only.
5. **Full with simultaneous read**: fill to 8 in PLAY, assert `data_ready` with 16'hBEEF exactly in a tick cycle → no `overflow`, `fifo_level` stays 8, and 16'hBEEF appears after the 7 older samples.
6. **Reset mid-playback**: assert reset for 1 cycle between two ticks → all outputs return to reset values next cycle, and the old samples never appear afterward.
